twos_to_signmag_serial: RTL and testbench
=========================================

TWOS_TO_SIGNMAG_SERIAL -- requirements
Module: twos_to_signmag_serial

Interface
REQ-001 Parameter: W, default 32, the operand width in bits; legal range is 2..64.
REQ-002 Port: clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 Port: rst_n, input, 1, reset; asynchronous assert, active-low.
REQ-004 Port: in_valid, input, 1, producer asserts that A holds an operand.
REQ-005 Port: in_ready, output, 1, block can accept an operand this cycle.
REQ-006 Port: A, input, W, two's-complement operand; sampled only on input handshake.
REQ-007 Port: out_valid, output, 1, S/M hold a finished result.
REQ-008 Port: out_ready, input, 1, consumer accepts the result this cycle.
REQ-009 Port: S, output, 1, sign of the result; 1 means negative.
REQ-010 Port: M, output, W, unsigned magnitude |A|.
REQ-011 Port: busy, output, 1, high while in CONV state.

Function
REQ-012 The FSM SHALL have three states: IDLE, CONV and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; busy SHALL be 1 only in CONV.
REQ-014 Input handshake = in_valid && in_ready at a rising edge; on it the block SHALL capture A into a shift register, capture S = A[W-1], clear the bit counter and the seen-one flag, and enter CONV.
REQ-015 In CONV the block SHALL process exactly one bit per cycle, LSB first: bit i at the i-th edge after the handshake (i = 0..W-1).
REQ-016 Per-bit rule when S=0: output bit = input bit.
REQ-017 Per-bit rule when S=1: output bit = input bit while seen-one=0 (including the first 1); output bit = inverted input bit after that. seen-one SHALL set on the first input 1.
REQ-018 Result bits SHALL shift into M from the MSB end, so that M holds the full result once all W bits are processed.
REQ-019 After the W-th CONV edge the FSM SHALL enter DONE; latency from input handshake to out_valid high is W+1 edges, fixed and independent of data.
REQ-020 In DONE, S and M SHALL hold stable until out_ready=1 is sampled; backpressure of any length SHALL be tolerated without loss.
REQ-021 Output handshake (out_valid && out_ready) SHALL move the FSM to IDLE; in_ready is therefore high one cycle later, with no same-cycle re-accept.
REQ-022 in_valid, A and out_ready SHALL be ignored while in CONV.
REQ-023 Boundary cases: A = -2^(W-1) SHALL yield S=1, M=2^(W-1), with no overflow flag. A=0 SHALL yield S=0, M=0. A=all-ones SHALL yield S=1, M=1.
REQ-024 The bit counter SHALL be ceil(log2(W+1)) bits wide and SHALL NOT wrap within an operation.
REQ-025 S and M SHALL change only on an input handshake, during CONV, or on reset.

Reset
REQ-026 While rst_n=0 the block SHALL immediately be in IDLE with in_ready=1, out_valid=0, busy=0, S=0, M=0, the counter at 0 and seen-one at 0.
REQ-027 Reset asserted in CONV or DONE SHALL abort the operation and discard any partial or pending result.
REQ-028 On the first edge after rst_n deasserts, an input handshake SHALL be accepted if in_valid=1.

Verification
REQ-029 With W=32, A=0x00000005, out_ready=1 -> out_valid at edge 33 after accept, S=0, M=0x00000005.
REQ-030 A=0xFFFFFFFB -> S=1, M=0x00000005; A=0xFFFFFFFF -> S=1, M=0x00000001; A=0 -> S=0, M=0.
REQ-031 A=0x80000000 -> S=1, M=0x80000000; A=0x7FFFFFFF -> S=0, M=0x7FFFFFFF.
REQ-032 Hold out_ready=0 for 10 cycles after out_valid, while toggling in_valid and A -> S/M unchanged, in_ready=0; raising out_ready -> in_ready=1 on the next cycle.
REQ-033 Assert rst_n=0 at the 16th CONV cycle -> out_valid, busy, S and M go to 0 immediately; a new operand (A=0xFFFFFF00) afterwards -> S=1, M=0x00000100.
REQ-034 Run 1000 random operands back-to-back with random in_valid/out_ready gaps -> every result matches the sign and |A| computed by the reference model, in order, with none dropped or duplicated.

Source files
------------

// File: rtl/twos_to_signmag_serial.sv
`default_nettype none
// ============================================================================
// Module   : twos_to_signmag_serial
// Function : Bit-serial two's-complement to sign/magnitude converter (LSB first)
// Revision : 1.0
// ============================================================================
module twos_to_signmag_serial #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         S,
  output logic [W-1:0] M,
  output logic         busy
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   shreg;
  logic [CW-1:0]  cnt;
  logic           seen_one;
  logic           accept;
  logic           deliver;
  logic           out_bit;

  assign in_ready  = (state == IDLE);
  assign busy      = (state == CONV);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;

  // Negative operands: copy up to and including the first 1, invert the rest.
  assign out_bit = shreg[0] ^ (S & seen_one);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CONV;
      CONV:    if (cnt == LAST) state_nxt = DONE;
      DONE:    if (deliver) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      cnt      <= '0;
      seen_one <= 1'b0;
      S        <= 1'b0;
      M        <= '0;
    end else if (accept) begin
      shreg    <= A;
      S        <= A[W-1];
      cnt      <= '0;
      seen_one <= 1'b0;
    end else if (state == CONV) begin
      shreg    <= shreg >> 1;
      M        <= {out_bit, M[W-1:1]};
      seen_one <= seen_one | shreg[0];
      cnt      <= cnt + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_twos_to_signmag_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_twos_to_signmag_serial
// Function : Scoreboard bench for twos_to_signmag_serial with random traffic
// Revision : 1.0
// ============================================================================
module tb_twos_to_signmag_serial;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic         out_valid;
  logic         out_ready;
  logic         S;
  logic [W-1:0] M;
  logic         busy;

  twos_to_signmag_serial #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .M         (M),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  logic [W:0] exp_q[$];
  int         acc_q[$];
  int         total = 0;
  int         bad = 0;
  int         pushed = 0;
  int         popped = 0;
  int         ready_mode = 0;  // 0: always ready, 1: random, 2: stalled

  // Reference: sign is the MSB, magnitude is the absolute value of the signed number.
  function automatic logic [W:0] model(input logic [W-1:0] a);
    logic signed [W-1:0] sa;
    logic [W-1:0]        mag;
    sa  = a;
    mag = (sa < 0) ? W'(-sa) : W'(sa);
    return {a[W-1], mag};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input int gap);
    int g;
    int guard;
    g = gap;
    guard = 0;
    forever begin
      if (!in_ready) begin
        in_valid = 1'($urandom);
        A = $urandom;
      end else if (g > 0) begin
        in_valid = 1'b0;
        g--;
      end else begin
        in_valid = 1'b1;
        A = a;
        exp_q.push_back(model(a));
        acc_q.push_back(cycle + 1);
        pushed++;
        break;
      end
      step();
      guard++;
      if (guard > 5000) begin
        $display("FAIL send_timeout: got no in_ready expected in_ready=1");
        $fatal(1, "input handshake never happened");
      end
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: owns out_ready, pops the scoreboard on every output handshake.
  initial begin : monitor
    logic       prev_ov;
    logic [W:0] held;
    logic [W:0] e;
    prev_ov   = 1'b0;
    held      = '0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov   = 1'b0;
        out_ready = 1'b0;
      end else if (out_valid) begin
        if (!prev_ov) begin
          held = {S, M};
          if (acc_q.size() != 0)
            chk("latency_edges", 64'(cycle - acc_q[0] + 1), 64'(W + 1));
        end else begin
          chk("done_hold", 64'({S, M}), 64'(held));
        end
        case (ready_mode)
          0:       out_ready = 1'b1;
          1:       out_ready = ($urandom_range(0, 3) != 0);
          default: out_ready = 1'b0;
        endcase
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_result: got S=%0d M=%0h expected no result", S, M);
          end else begin
            e = exp_q.pop_front();
            void'(acc_q.pop_front());
            chk("sign", 64'(S), 64'(e[W]));
            chk("mag", 64'(M), 64'(e[W-1:0]));
            popped++;
          end
        end
        prev_ov = 1'b1;
      end else begin
        out_ready = 1'($urandom);
        prev_ov   = 1'b0;
      end
    end
  end

  initial begin : main
    logic [W-1:0] dir[6];
    logic [W:0]   e;
    int           n;
    dir = '{32'h0000_0005, 32'hFFFF_FFFB, 32'hFFFF_FFFF,
            32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
    rst_n = 1'b0;
    in_valid = 1'b0;
    A = '0;
    repeat (2) step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_S", 64'(S), 64'd0);
    chk("rst_M", 64'(M), 64'd0);
    rst_n = 1'b1;

    // Directed operands with an always-ready consumer
    ready_mode = 0;
    foreach (dir[i]) send(dir[i], 0);
    drain(200);

    // Long backpressure while the producer toggles junk
    ready_mode = 2;
    e = model(32'hFFFF_1234);
    send(32'hFFFF_1234, 0);
    n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    chk("hold_reached_done", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      chk("hold_S", 64'(S), 64'(e[W]));
      chk("hold_M", 64'(M), 64'(e[W-1:0]));
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      in_valid = 1'($urandom);
      A = $urandom;
      step();
    end
    in_valid = 1'b0;
    ready_mode = 0;
    step();
    chk("release_in_ready_same", 64'(in_ready), 64'd0);
    step();
    chk("release_in_ready_next", 64'(in_ready), 64'd1);
    drain(50);

    // Reset in the middle of a conversion
    send($urandom, 0);
    chk("conv_busy", 64'(busy), 64'd1);
    repeat (15) step();
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_S", 64'(S), 64'd0);
    chk("abort_M", 64'(M), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    acc_q.delete();
    pushed--;
    repeat (2) step();
    rst_n = 1'b1;
    send(32'hFFFF_FF00, 0);
    chk("accept_after_reset", 64'(busy), 64'd1);
    drain(100);

    // Random back-to-back traffic with random gaps and backpressure
    ready_mode = 1;
    for (int k = 0; k < 1000; k++) begin
      logic [W-1:0] v;
      case ($urandom_range(0, 9))
        0:       v = 32'h0000_0000;
        1:       v = 32'hFFFF_FFFF;
        2:       v = 32'h8000_0000;
        3:       v = 32'h7FFF_FFFF;
        default: v = $urandom;
      endcase
      send(v, $urandom_range(0, 3));
    end
    drain(2000);
    chk("result_count", 64'(popped), 64'(pushed));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
